bin_morph3x3: RTL and testbench

Binary 3x3 morphological filter for the edge-detection video pipeline. It sits directly downstream of the grayscale binarisation stage and consumes its 1-bit pixel stream with vld/sop/eop framing. It applies erosion, or optionally dilation, over a 3x3 window built from two line buffers. It emits a cleaned 1-bit stream with the same framing for the SDRAM write path.

---
 rtl/bin_morph_pkg.sv | 24 ++
 rtl/line_buf_1b.sv | 34 +++
 rtl/bin_morph3x3.sv | 202 ++++++++++++++++++++
 tb/tb_bin_morph3x3.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/bin_morph_pkg.sv
// ============================================================================
// Module   : bin_morph_pkg
// Brief    : Shared constants and types for the binary 3x3 morphology filter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bin_morph_pkg;

    localparam int c_IMG_W_DEF = 640;
    localparam int c_IMG_H_DEF = 480;
    localparam int c_CNT_W_DEF = 10;

    // Rows/cols closer than this to the frame origin lack a full 3x3 window
    localparam int c_BORDER    = 2;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

endpackage : bin_morph_pkg

`default_nettype wire

// File: rtl/line_buf_1b.sv
// ============================================================================
// Module   : line_buf_1b
// Brief    : 1-bit x IMG_W line buffer, combinational read-before-write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_buf_1b
    import bin_morph_pkg::*;
#(
    parameter int IMG_W = c_IMG_W_DEF,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic          i_wdata,
    output logic          o_rdata
);

    // No reset: contents from earlier lines/frames are hidden by border masking
    logic r_mem [IMG_W];

    assign o_rdata = r_mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

endmodule : line_buf_1b

`default_nettype wire

// File: rtl/bin_morph3x3.sv
// ============================================================================
// Module   : bin_morph3x3
// Brief    : Binary 3x3 erosion (dilation with BIN_MORPH_DILATE_EN), 2-clk latency.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bin_morph3x3
    import bin_morph_pkg::*;
#(
    parameter int IMG_W = c_IMG_W_DEF,
    parameter int IMG_H = c_IMG_H_DEF,
    parameter int CNT_W = c_CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    input  logic din_vld,
    input  logic din_sop,
    input  logic din_eop,
`ifdef BIN_MORPH_DILATE_EN
    input  logic op_dilate,
`endif
    output logic dout,
    output logic dout_vld,
    output logic dout_sop,
    output logic dout_eop
);

    localparam int               c_AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CNT_W-1:0] c_COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] c_ROW_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_MARGIN   = CNT_W'(c_BORDER);

    if (((1 << CNT_W) < IMG_W) || ((1 << CNT_W) < IMG_H)) begin : g_bad_dims
        $error("bin_morph3x3: CNT_W too narrow for IMG_W/IMG_H");
    end

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_acc;
    logic [CNT_W-1:0] r_col;
    logic [CNT_W-1:0] r_row;
    logic [CNT_W-1:0] w_col;
    logic [CNT_W-1:0] w_row;
    logic [CNT_W-1:0] w_col_nxt;
    logic [CNT_W-1:0] w_row_nxt;
    logic             w_b0;
    logic             w_b1;

    logic [2:0]       r_win0;
    logic [2:0]       r_win1;
    logic [2:0]       r_win2;
    logic             r_p1_vld;
    logic             r_p1_sop;
    logic             r_p1_eop;
    logic [CNT_W-1:0] r_p1_col;
    logic [CNT_W-1:0] r_p1_row;
    logic             w_inner;
    logic             w_res;

    logic             r_dout;
    logic             r_dout_vld;
    logic             r_dout_sop;
    logic             r_dout_eop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (din_vld) begin
            if (din_sop) begin
                w_state_nxt = din_eop ? ST_IDLE : ST_ACTIVE;
            end else if ((r_state == ST_ACTIVE) && din_eop) begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    always_comb begin
        w_acc = din_vld & ((r_state == ST_ACTIVE) | din_sop);
    end

    // sop forces the origin so a restarted frame needs no counter clear first
    assign w_col = din_sop ? '0 : r_col;
    assign w_row = din_sop ? '0 : r_row;

    always_comb begin
        w_col_nxt = w_col + 1'b1;
        w_row_nxt = w_row;
        if (w_col == c_COL_LAST) begin
            w_col_nxt = '0;
            if (w_row != c_ROW_MAX) begin
                w_row_nxt = w_row + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_acc) begin
            r_col <= w_col_nxt;
            r_row <= w_row_nxt;
        end
    end

    // buf0 holds row-1; its old value cascades into buf1 (row-2)
    line_buf_1b #(.IMG_W(IMG_W), .AW(c_AW)) u_buf0 (
        .clk     (clk),
        .i_we    (w_acc),
        .i_addr  (w_col[c_AW-1:0]),
        .i_wdata (din),
        .o_rdata (w_b0)
    );

    line_buf_1b #(.IMG_W(IMG_W), .AW(c_AW)) u_buf1 (
        .clk     (clk),
        .i_we    (w_acc),
        .i_addr  (w_col[c_AW-1:0]),
        .i_wdata (w_b0),
        .o_rdata (w_b1)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_win0   <= '0;
            r_win1   <= '0;
            r_win2   <= '0;
            r_p1_vld <= 1'b0;
            r_p1_sop <= 1'b0;
            r_p1_eop <= 1'b0;
            r_p1_col <= '0;
            r_p1_row <= '0;
        end else begin
            r_p1_vld <= w_acc;
            r_p1_sop <= w_acc & din_sop;
            r_p1_eop <= w_acc & din_eop;
            if (w_acc) begin
                r_win0   <= {r_win0[1:0], din};
                r_win1   <= {r_win1[1:0], w_b0};
                r_win2   <= {r_win2[1:0], w_b1};
                r_p1_col <= w_col;
                r_p1_row <= w_row;
            end
        end
    end

    assign w_inner = (r_p1_col >= c_MARGIN) && (r_p1_row >= c_MARGIN);

`ifdef BIN_MORPH_DILATE_EN
    logic r_op;
    logic r_p1_op;
    logic w_op;

    // Operation latched on the sop pixel and held for the whole frame
    assign w_op = din_sop ? op_dilate : r_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op    <= 1'b0;
            r_p1_op <= 1'b0;
        end else if (w_acc) begin
            r_op    <= w_op;
            r_p1_op <= w_op;
        end
    end

    assign w_res = r_p1_op ? (|{r_win2, r_win1, r_win0}) : (&{r_win2, r_win1, r_win0});
`else
    assign w_res = &{r_win2, r_win1, r_win0};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout     <= 1'b0;
            r_dout_vld <= 1'b0;
            r_dout_sop <= 1'b0;
            r_dout_eop <= 1'b0;
        end else begin
            r_dout     <= r_p1_vld & w_inner & w_res;
            r_dout_vld <= r_p1_vld;
            r_dout_sop <= r_p1_vld & r_p1_sop;
            r_dout_eop <= r_p1_vld & r_p1_eop;
        end
    end

    assign dout     = r_dout;
    assign dout_vld = r_dout_vld;
    assign dout_sop = r_dout_sop;
    assign dout_eop = r_dout_eop;

endmodule : bin_morph3x3

`default_nettype wire

// File: tb/tb_bin_morph3x3.sv
// ============================================================================
// Module   : tb_bin_morph3x3
// Brief    : Scoreboard bench for bin_morph3x3 on an 8x6 image (BIN_MORPH_DILATE_EN optional).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bin_morph3x3;

    localparam int c_W  = 8;
    localparam int c_H  = 6;
    localparam int c_CW = 4;

    typedef struct {
        logic d;
        logic s;
        logic e;
        int   due;
    } exp_t;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic din       = 1'b0;
    logic din_vld   = 1'b0;
    logic din_sop   = 1'b0;
    logic din_eop   = 1'b0;
    logic op_dilate = 1'b0;
    logic dout;
    logic dout_vld;
    logic dout_sop;
    logic dout_eop;

    exp_t q[$];
    exp_t r_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;

    bin_morph3x3 #(.IMG_W(c_W), .IMG_H(c_H), .CNT_W(c_CW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_vld   (din_vld),
        .din_sop   (din_sop),
        .din_eop   (din_eop),
`ifdef BIN_MORPH_DILATE_EN
        .op_dilate (op_dilate),
`endif
        .dout      (dout),
        .dout_vld  (dout_vld),
        .dout_sop  (dout_sop),
        .dout_eop  (dout_eop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expectation per dout_vld, flags unexpected/missing/late outputs
    always @(negedge clk) begin
        if (!rst_n) begin
            n_vec++;
            if ({dout, dout_vld, dout_sop, dout_eop} !== 4'b0000) begin
                n_err++;
                $display("FAIL reset_outputs cyc=%0d: got d/v/s/e=%b%b%b%b want 0000",
                         cyc, dout, dout_vld, dout_sop, dout_eop);
            end
        end else if (dout_vld) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_output cyc=%0d: got d/s/e=%b%b%b want no output",
                         cyc, dout, dout_sop, dout_eop);
            end else begin
                r_e = q.pop_front();
                if (dout !== r_e.d || dout_sop !== r_e.s || dout_eop !== r_e.e || cyc != r_e.due) begin
                    n_err++;
                    $display("FAIL pixel cyc=%0d: got d/s/e=%b%b%b want %b%b%b due cyc=%0d",
                             cyc, dout, dout_sop, dout_eop, r_e.d, r_e.s, r_e.e, r_e.due);
                end
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            n_vec++;
            n_err++;
            $display("FAIL missing_output cyc=%0d: got no dout_vld want d/s/e=%b%b%b",
                     cyc, q[0].d, q[0].s, q[0].e);
            void'(q.pop_front());
        end
    end

    task automatic drive(input logic v, input logic d, input logic s, input logic eo);
        @(negedge clk);
        din_vld = v;
        din     = d;
        din_sop = s;
        din_eop = eo;
    endtask

    // Called right after drive(): the pixel is sampled at the coming edge, output 2 edges on
    task automatic expect_px(input logic d, input logic s, input logic eo);
        exp_t x;
        x.d   = d;
        x.s   = s;
        x.e   = eo;
        x.due = cyc + 2;
        q.push_back(x);
    endtask

    // kind 0: all ones; 1: single one at (3,4); 2: all ones with a zero at (3,4)
    function automatic logic pix(input int kind, input int r, input int c);
        case (kind)
            1:       return (r == 3 && c == 4);
            2:       return !(r == 3 && c == 4);
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic exp_of(input int kind, input int r, input int c);
        logic inner;
        logic blk;
        inner = (r >= 2) && (c >= 2);
        blk   = (r >= 3 && r <= 5) && (c >= 4 && c <= 6);
        case (kind)
            1:       return blk;
            2:       return inner && !blk;
            default: return inner;
        endcase
    endfunction

    task automatic send_frame(input int kind, input bit gaps);
        logic s;
        logic eo;
        for (int r = 0; r < c_H; r++) begin
            for (int c = 0; c < c_W; c++) begin
                if (gaps) begin
                    for (int g = 0; g < 3 && $urandom_range(0, 1) == 1; g++) begin
                        drive(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
                    end
                end
                s  = (r == 0 && c == 0);
                eo = (r == c_H - 1 && c == c_W - 1);
                drive(1'b1, pix(kind, r, c), s, eo);
                expect_px(exp_of(kind, r, c), s, eo);
            end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Pixels with no preceding sop are dropped
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b1, 1'b0, (i == 4));
        idle(4);

        op_dilate = 1'b0;
        send_frame(0, 1'b0);
        idle(4);
        send_frame(0, 1'b1);
        idle(4);

`ifdef BIN_MORPH_DILATE_EN
        op_dilate = 1'b1;
        send_frame(1, 1'b0);
        idle(4);
        op_dilate = 1'b0;
`endif

        send_frame(2, 1'b0);
        idle(4);

        // Partial frame, then asynchronous reset mid-frame
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 1'b1, (i == 0), 1'b0);
            expect_px(1'b0, (i == 0), 1'b0);
        end
        @(negedge clk);
        #2;
        din_vld = 1'b0;
        din_sop = 1'b0;
        rst_n   = 1'b0;
        while (q.size() != 0 && q[$].due > cyc) void'(q.pop_back());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        send_frame(0, 1'b0);
        idle(4);

        // One-pixel frame, then stray pixels must be dropped in IDLE
        drive(1'b1, 1'b1, 1'b1, 1'b1);
        expect_px(1'b0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 1'b0, 1'b0);
        idle(10);

        while (q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL leftover_expectation: got no output want d/s/e=%b%b%b due cyc=%0d",
                     q[0].d, q[0].s, q[0].e, q[0].due);
            void'(q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_bin_morph3x3

`default_nettype wire
